// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared types and helpers for the reg_bank register file.
// Holds the clear-sequencer state encoding and the init-vector slice helper.
package reg_bank_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   // Upper bounds for the generic slice helper; INIT_VAL is zero-extended
   // to INIT_MAX_BITS and each slice is returned zero-extended to SLICE_MAX_W.
   localparam int unsigned SLICE_MAX_W   = 64;
   localparam int unsigned INIT_MAX_BITS = 4096;

   // Returns entry idx of a packed init vector whose entries are width bits.
   function automatic logic [SLICE_MAX_W-1:0] init_slice(
      input logic [INIT_MAX_BITS-1:0] init_val,
      input int unsigned              idx,
      input int unsigned              width
   );
      logic [INIT_MAX_BITS-1:0] shifted;
      logic [SLICE_MAX_W-1:0]   mask;
      shifted = init_val >> (idx * width);
      if (width >= SLICE_MAX_W)
         mask = '1;
      else
         mask = (SLICE_MAX_W'(1) << width) - SLICE_MAX_W'(1);
      return shifted[SLICE_MAX_W-1:0] & mask;
   endfunction

endpackage

// File: rtl/reg_bank_clr_seq.sv
// reg_bank_clr_seq: clear sequencer for reg_bank.
// Walks a pointer over every entry (one per cycle) and reports busy/clr_done.
module reg_bank_clr_seq
   import reg_bank_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_done,
   output logic          clr_en,
   output logic [AW-1:0] clr_ptr
);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // State register: FSM state, pointer and the registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: requests arriving outside IDLE are ignored, not queued.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            ptr_d = '0;
            if (clr_req) state_d = CLEAR;
         end
         CLEAR: begin
            if (ptr_q == AW'(DEPTH - 1)) begin
               ptr_d   = '0;
               state_d = DONE;
            end else begin
               ptr_d = ptr_q + AW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Output logic: status is decoded from the next state so it lands in a flop.
   always_comb begin
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign busy     = busy_q;
   assign clr_done = done_q;
   assign clr_en   = (state_q == CLEAR);
   assign clr_ptr  = ptr_q;

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank, one write port, two registered read
// ports with write-first bypass, and a sequenced clear back to INIT_VAL.
// Optional macro REG_BANK_ZERO_REG_EN hardwires entry 0 to zero.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int                     WIDTH    = 8,
   parameter int                     DEPTH    = 8,
   parameter logic [DEPTH*WIDTH-1:0] INIT_VAL = '0,
   localparam int                    AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b,
   input  logic             clr_req,
   output logic             busy,
   output logic             clr_done
);

`ifdef REG_BANK_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic [WIDTH-1:0]       mem_d [DEPTH];
   logic [WIDTH-1:0]       init_arr [DEPTH];
   logic [SLICE_MAX_W-1:0] init_full [DEPTH];
   logic                   clr_en;
   logic [AW-1:0]          clr_ptr;
   logic                   wr_ok;

   // Per-entry init values; entry 0 is forced to zero when it is hardwired.
   for (genvar g = 0; g < DEPTH; g++) begin : g_init
      assign init_full[g] = init_slice(INIT_MAX_BITS'(INIT_VAL), g, WIDTH);
      assign init_arr[g]  = (ZERO_REG && g == 0) ? '0 : init_full[g][WIDTH-1:0];
   end

   reg_bank_clr_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .clr_en   (clr_en),
      .clr_ptr  (clr_ptr)
   );

   // Writes are dropped while the clear engine owns the array.
   assign wr_ok = we && !busy && (32'(waddr) < DEPTH)
                  && !(ZERO_REG && (waddr == '0));

   // Next array contents: accepted write, or the entry under the clear pointer.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      if (wr_ok)  mem_d[waddr]   = wdata;
      if (clr_en) mem_d[clr_ptr] = init_arr[clr_ptr];
   end

   // Array storage; reset restores every entry to its init value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= init_arr[i];
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Two identical registered read ports; bypass only applies to accepted writes.
   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] rd_d, rd_q;

      assign ra = (p == 0) ? raddr_a : raddr_b;

      // Select write data, array contents, or zero for invalid/hardwired addresses.
      always_comb begin
         rd_d = '0;
         if ((32'(ra) < DEPTH) && !(ZERO_REG && (ra == '0))) begin
            if (wr_ok && (waddr == ra)) rd_d = wdata;
            else                        rd_d = mem_q[ra];
         end
      end

      // Read data register.
      always_ff @(posedge clk) begin
         if (!rst) rd_q <= '0;
         else      rd_q <= rd_d;
      end
   end

   assign rdata_a = g_rd[0].rd_q;
   assign rdata_b = g_rd[1].rd_q;

endmodule

// File: doc/reg_bank.md
Name: reg_bank

Overview:
- Parametrised multi-entry register bank with per-entry reset/init values.
- One write port and two registered read ports.
- A sequenced clear engine restores every entry to its init value on request, without a global reset.
- Holds the RSSB machine's working registers (IP, accumulator, zero, I/O mirrors) and replaces the per-register single-entry storage in the datapath.

Parameters:
- WIDTH, 8, data width of each entry in bits.
- DEPTH, 8, number of entries; must be at least 2.
- AW, $clog2(DEPTH), address width; derived localparam, not overridable.
- INIT_VAL, '0, packed DEPTH*WIDTH vector; entry i takes INIT_VAL[i*WIDTH +: WIDTH].

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  registered read data, port A.
- raddr_b  in  AW  read address, port B.
- rdata_b  out  WIDTH  registered read data, port B.
- clr_req  in  1  single-cycle request to start the clear sequence.
- busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when the clear sequence finishes.

Behaviour:
- Reset (rst==0 at a rising edge):
  - every entry is loaded with its INIT_VAL slice;
  - rdata_a, rdata_b, busy and clr_done are 0;
  - clear pointer is 0 and the FSM is IDLE.
  - Reset mid-clear abandons the sequence; no clr_done pulse is produced.
- Write:
  - Accepted when we==1, busy==0 and waddr<DEPTH; the entry updates at that edge.
  - Out-of-range waddr is ignored.
- Read:
  - Latency is 1 cycle: rdata_x at edge N+1 reflects raddr_x sampled at edge N.
  - Out-of-range raddr returns 0.
  - Write-first bypass: if a write is accepted at the same edge and waddr==raddr_x, rdata_x gets wdata.
  - Both ports may read the same address.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req==1.
  - CLEAR: each cycle entry[ptr] is loaded with INIT[ptr], then ptr increments. When ptr==DEPTH-1, ptr resets to 0 and the FSM goes to DONE. The sequence takes exactly DEPTH cycles.
  - DONE: clr_done=1 for one cycle, then IDLE.
  - busy=1 in CLEAR and DONE, 0 in IDLE. busy and clr_done are registered state outputs.
- Simultaneous events and clear-time rules:
  - we and clr_req in the same IDLE cycle: the write is accepted; the clear starts on the next cycle and later overwrites that entry with its init value.
  - clr_req while busy is ignored, not queued.
  - Writes while busy are dropped silently.
  - Reads while busy return current array contents with no bypass. An entry reads its init value from the cycle after it is cleared.

Optional Feature:
- Macro REG_BANK_ZERO_REG_EN.
- Defined: entry 0 is hardwired to 0.
  - Reads of address 0 return 0.
  - Writes to address 0 are ignored, including for bypass.
  - The clear engine and reset leave entry 0 at 0 regardless of INIT_VAL.
- Undefined: entry 0 is an ordinary entry.

Decomposition:
- Shared package reg_bank_pkg:
  - state enum clr_state_e {IDLE, CLEAR, DONE};
  - function init_slice(INIT_VAL, idx) returning one WIDTH slice.
- The read port logic is instantiated twice inline, as a generate loop over 2 ports.
- Natural sub-module: reg_bank_clr_seq.
  - Contains the FSM, pointer, busy and clr_done.
  - Outputs: clr_en and clr_ptr to the array.

Test Plan (WIDTH=8, DEPTH=8, INIT_VAL: entry i = i*8'h11, macro undefined unless stated):
1. Hold rst=0 two cycles, then read addresses 0..7 on port A, one per cycle -> rdata_a = 00,11,22,...,77, each one cycle after its address.
2. Write 3<=A5, then read 3 on both ports -> rdata_a=rdata_b=A5. Same-cycle write 5<=3C with raddr_b=5 -> rdata_b=3C on the next edge (bypass).
3. Write all entries to FF, then pulse clr_req with we=1, waddr=2, wdata=99:
   - busy rises next cycle and holds 9 cycles (8 CLEAR + 1 DONE);
   - clr_done pulses once, in the final busy cycle;
   - entry 2 reads 99 before its clear slot, then 22;
   - all entries equal init values afterwards.
4. During clear: we=1 to addr 6 with 5A, plus a second clr_req -> write dropped, no restart; sequence still ends after 9 busy cycles; entry 6 reads 66.
5. Assert rst=0 at the 4th CLEAR cycle after writing 7<=EE -> all entries at init, busy=0, no clr_done pulse, entry 7 reads 77.
6. With REG_BANK_ZERO_REG_EN defined: write 0<=AB, read 0 -> 00; bypass read of 0 in the same cycle -> 00; the clear sequence leaves entry 0 at 00.
